// File: rtl/baud_gen_t.sv
// Programmable UART baud clock: divides the system clock to a 50%-duty square
// wave at 2400/4800/9600/19200 baud, selected by baud_rate.
module baud_gen_t #(
   parameter int CLK_FREQ_HZ = 50000000,
   // half-period counts, rounded to the nearest clock
   parameter int HALF_2400   = (CLK_FREQ_HZ + 2400)  / (2 * 2400),
   parameter int HALF_4800   = (CLK_FREQ_HZ + 4800)  / (2 * 4800),
   parameter int HALF_9600   = (CLK_FREQ_HZ + 9600)  / (2 * 9600),
   parameter int HALF_19200  = (CLK_FREQ_HZ + 19200) / (2 * 19200),
   parameter int CNT_W       = 14
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [1:0] baud_rate,
   output logic       baud_clk
);

   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] half_sel;
   logic [CNT_W-1:0] term;

   always_comb begin
      half_sel = CNT_W'(HALF_2400);
      case (baud_rate)
         2'b00:   half_sel = CNT_W'(HALF_2400);
         2'b01:   half_sel = CNT_W'(HALF_4800);
         2'b10:   half_sel = CNT_W'(HALF_9600);
         2'b11:   half_sel = CNT_W'(HALF_19200);
         default: half_sel = CNT_W'(HALF_2400);
      endcase
   end

   assign term = half_sel - CNT_W'(1);

   // >= so a slow-to-fast rate switch mid-count toggles on the next clock
   // instead of running the counter around to wrap.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count    <= '0;
         baud_clk <= 1'b0;
      end else if (count >= term) begin
         count    <= '0;
         baud_clk <= ~baud_clk;
      end else begin
         count    <= count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_baud_gen_t.sv
// Scoreboard bench for baud_gen_t: stimulus queues expected toggle intervals,
// a monitor measures clocks between baud_clk edges and compares.
module tb_baud_gen_t;

   logic       clock;
   logic       reset_n;
   logic [1:0] baud_rate;
   logic       baud_clk;

   typedef struct {
      string       tag;
      int unsigned ivl;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned checks = 0;
   int unsigned fails  = 0;

   baud_gen_t dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .baud_rate (baud_rate),
      .baud_clk  (baud_clk)
   );

   initial clock = 1'b0;
   always #10 clock = ~clock;

   task automatic expect_ivl(input string tag, input int unsigned ivl);
      exp_t e;
      e.tag = tag;
      e.ivl = ivl;
      exp_q.push_back(e);
   endtask

   task automatic check_lvl(input string tag, input logic got, input logic want);
      checks++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s baud_clk got %b expected %b", tag, got, want);
      end
   endtask

   // Each loop iteration ends 2 time units after a rising edge.
   task automatic wait_drain(input int unsigned limit);
      int unsigned k;
      k = 0;
      while (exp_q.size() != 0 && k < limit) begin
         @(posedge clock);
         #2;
         k++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         fails++;
         $display("FAIL timeout_%s toggle not seen within %0d clocks, %0d pending",
                  exp_q[0].tag, limit, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic wait_edges(input int unsigned n);
      repeat (n) @(posedge clock);
      #2;
   endtask

   // monitor: clocks since last toggle (or since reset release)
   initial begin
      int unsigned cnt;
      logic        prev;
      exp_t        e;
      cnt  = 0;
      prev = 1'b0;
      forever begin
         @(posedge clock);
         #1;
         if (!reset_n) begin
            cnt  = 0;
            prev = 1'b0;
         end else begin
            cnt++;
            if (baud_clk !== prev) begin
               prev = baud_clk;
               checks++;
               if (exp_q.size() == 0) begin
                  fails++;
                  $display("FAIL unexpected_toggle interval %0d clocks, none expected", cnt);
               end else begin
                  e = exp_q.pop_front();
                  if (cnt != e.ivl) begin
                     fails++;
                     $display("FAIL %s interval got %0d clocks expected %0d", e.tag, cnt, e.ivl);
                  end
               end
               cnt = 0;
            end
         end
      end
   end

   initial begin
      reset_n   = 1'b0;
      baud_rate = 2'b00;

      // reset held for 100 ns with clock running
      repeat (5) begin
         @(posedge clock);
         #1;
         check_lvl("in_reset", baud_clk, 1'b0);
      end

      // rate 00: first rise 10417 clocks after release, then one full period
      expect_ivl("r00_first_rise", 10417);
      expect_ivl("r00_low", 10417);
      @(negedge clock);
      reset_n = 1'b1;
      wait_drain(25000);

      baud_rate = 2'b01;
      expect_ivl("r01_high", 5208);
      expect_ivl("r01_low", 5208);
      wait_drain(12000);

      baud_rate = 2'b10;
      expect_ivl("r10_high", 2604);
      expect_ivl("r10_low", 2604);
      wait_drain(6000);

      baud_rate = 2'b11;
      expect_ivl("r11_high", 1302);
      expect_ivl("r11_low", 1302);
      wait_drain(3000);

      // slow-to-fast: counter at 8000 on rate 00, switch to 11
      baud_rate = 2'b00;
      wait_edges(8000);
      baud_rate = 2'b11;
      expect_ivl("s2f_next_clock", 8001);
      expect_ivl("s2f_then_1302a", 1302);
      expect_ivl("s2f_then_1302b", 1302);
      wait_drain(12000);

      // fast-to-slow: counter at 600 on rate 11, switch to 00 and keep counting
      wait_edges(600);
      baud_rate = 2'b00;
      expect_ivl("f2s_continue", 10417);
      wait_drain(12000);

      // async reset while baud_clk is high
      baud_rate = 2'b11;
      expect_ivl("pre_reset_rise", 1302);
      wait_drain(3000);
      wait_edges(300);
      check_lvl("before_async_reset", baud_clk, 1'b1);
      #3;
      reset_n = 1'b0;
      #1;
      check_lvl("async_reset_drop", baud_clk, 1'b0);
      repeat (3) @(posedge clock);
      #1;
      check_lvl("async_reset_hold", baud_clk, 1'b0);
      expect_ivl("post_reset_rise", 1302);
      @(negedge clock);
      reset_n = 1'b1;
      wait_drain(3000);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
